// File: rtl/codec_cfg_pkg.sv
// Shared configuration for the codec init sequencer: state codes, WM8731
// register addresses and the helper that packs an address/data pair.
package codec_cfg_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_PWR  = 4'd1,
    ST_ISSUE     = 4'd2,
    ST_WAIT_RESP = 4'd3,
    ST_GAP       = 4'd4,
    ST_DONE      = 4'd5,
    ST_ERROR     = 4'd6
  } state_t;

  localparam int IDX_W = 4;
  localparam int CMD_W = 16;

  localparam logic [6:0] REG_LINVOL = 7'h00;
  localparam logic [6:0] REG_RINVOL = 7'h01;
  localparam logic [6:0] REG_LHPVOL = 7'h02;
  localparam logic [6:0] REG_RHPVOL = 7'h03;
  localparam logic [6:0] REG_APATH  = 7'h04;
  localparam logic [6:0] REG_DPATH  = 7'h05;
  localparam logic [6:0] REG_PWR    = 7'h06;
  localparam logic [6:0] REG_IFACE  = 7'h07;
  localparam logic [6:0] REG_SRATE  = 7'h08;
  localparam logic [6:0] REG_ACTIVE = 7'h09;
  localparam logic [6:0] REG_RESET  = 7'h0F;

  // WM8731 frames each write as a 7-bit address followed by 9 data bits.
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [6:0] addr7,
                                                 input logic [8:0] data9);
    return {addr7, data9};
  endfunction

endpackage

// File: rtl/codec_reg_rom.sv
// Fixed codec bring-up table; index selects one packed 16-bit register write.
module codec_reg_rom
  import codec_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [CMD_W-1:0] word
);

  always_comb begin
    word = 16'h0000;
    case (index)
      4'd0:    word = pack_cmd(REG_RESET,  9'h000);
      4'd1:    word = pack_cmd(REG_PWR,    9'h010);  // everything up except outputs
      4'd2:    word = pack_cmd(REG_LINVOL, 9'h017);
      4'd3:    word = pack_cmd(REG_RINVOL, 9'h017);
      4'd4:    word = pack_cmd(REG_APATH,  9'h012);
      4'd5:    word = pack_cmd(REG_DPATH,  9'h000);
      4'd6:    word = pack_cmd(REG_IFACE,  9'h002);
      4'd7:    word = pack_cmd(REG_SRATE,  9'h000);
      4'd8:    word = pack_cmd(REG_PWR,    9'h000);
      4'd9:    word = pack_cmd(REG_ACTIVE, 9'h001);
      default: word = 16'h0000;
    endcase
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec register table after reset, issuing one I2C write per entry
// with bounded NACK retries, and reports progress for the top-level display.
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         NUM_REGS      = 10,
  parameter logic [6:0] DEV_ADDR      = 7'h1A,
  parameter int         MAX_RETRIES   = 3,
  parameter int         STARTUP_DELAY = 1000,
  parameter int         GAP_CYCLES    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [6:0]       cmd_dev_addr,
  output logic [7:0]       cmd_byte0,
  output logic [7:0]       cmd_byte1,
  input  logic             resp_valid,
  input  logic             resp_ack_err,
  output logic             init_done,
  output logic             init_error,
  output logic [IDX_W-1:0] cur_index,
  output logic [3:0]       state_info
);

  localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

  // A zero delay collapses to a terminal count of 0, i.e. leave after one cycle.
  localparam logic [31:0] PWR_LAST = (STARTUP_DELAY > 0) ? 32'(STARTUP_DELAY - 1) : 32'd0;
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t             state_reg,     state_next;
  logic [31:0]        counter_reg,   counter_next;
  logic [IDX_W-1:0]   index_reg,     index_next;
  logic [RETRY_W-1:0] retry_reg,     retry_next;
  logic               cmd_valid_reg, cmd_valid_next;
  logic [CMD_W-1:0]   cmd_word_reg;
  logic [IDX_W-1:0]   rom_index;
  logic [CMD_W-1:0]   rom_word;

  // Look up the entry that will be current after this edge so the command
  // bytes are already valid when cmd_valid rises.
  assign rom_index = reset ? '0 : index_next;

  codec_reg_rom u_rom (
    .index (rom_index),
    .word  (rom_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_WAIT_PWR;
      counter_reg   <= '0;
      index_reg     <= '0;
      retry_reg     <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_word_reg  <= rom_word;
    end else begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      index_reg     <= index_next;
      retry_reg     <= retry_next;
      cmd_valid_reg <= cmd_valid_next;
      if (!cmd_valid_reg)
        cmd_word_reg <= rom_word;
    end
  end

  always_comb begin
    state_next     = state_reg;
    counter_next   = counter_reg;
    index_next     = index_reg;
    retry_next     = retry_reg;
    cmd_valid_next = cmd_valid_reg;
    case (state_reg)
      ST_WAIT_PWR: begin
        if (counter_reg == PWR_LAST) begin
          state_next   = ST_ISSUE;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + 32'd1;
        end
      end
      ST_ISSUE: begin
        if (!cmd_valid_reg) begin
          cmd_valid_next = 1'b1;
        end else if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if (resp_valid) begin
          if (!resp_ack_err) begin
            if (index_reg == LAST_IDX) begin
              state_next = ST_DONE;
            end else begin
              index_next   = index_reg + IDX_W'(1);
              retry_next   = '0;
              counter_next = '0;
              state_next   = ST_GAP;
            end
          end else if (retry_reg < RETRY_MAX) begin
            retry_next   = retry_reg + RETRY_W'(1);
            counter_next = '0;
            state_next   = ST_GAP;
          end else begin
            state_next = ST_ERROR;
          end
        end
      end
      ST_GAP: begin
        if (counter_reg == GAP_LAST) begin
          state_next   = ST_ISSUE;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + 32'd1;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next   = ST_WAIT_PWR;
          counter_next = '0;
          index_next   = '0;
          retry_next   = '0;
        end
      end
      default: begin
        state_next     = ST_WAIT_PWR;
        counter_next   = '0;
        index_next     = '0;
        retry_next     = '0;
        cmd_valid_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    init_done  = (state_reg == ST_DONE);
    init_error = (state_reg == ST_ERROR);
    state_info = state_reg;
  end

  assign cmd_valid    = cmd_valid_reg;
  assign cmd_dev_addr = DEV_ADDR;
  assign cmd_byte0    = cmd_word_reg[15:8];
  assign cmd_byte1    = cmd_word_reg[7:0];
  assign cur_index    = index_reg;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Scenario table plus hand-written corner sequences for the codec init sequencer.
module tb_codec_init_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_byte0;
  logic [7:0] cmd_byte1;
  logic       resp_valid = 1'b0;
  logic       resp_ack_err = 1'b0;
  logic       init_done;
  logic       init_error;
  logic [3:0] cur_index;
  logic [3:0] state_info;

  codec_init_sequencer #(
    .NUM_REGS      (3),
    .DEV_ADDR      (7'h1A),
    .MAX_RETRIES   (3),
    .STARTUP_DELAY (5),
    .GAP_CYCLES    (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_byte0    (cmd_byte0),
    .cmd_byte1    (cmd_byte1),
    .resp_valid   (resp_valid),
    .resp_ack_err (resp_ack_err),
    .init_done    (init_done),
    .init_error   (init_error),
    .cur_index    (cur_index),
    .state_info   (state_info)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] b0;
    logic [7:0] b1;
  } exp_t;

  typedef struct {
    int         n0, n1, n2;   // NACKs the master returns for entries 0..2
    logic       exp_done;
    logic       exp_error;
    logic [3:0] exp_state;
    logic [3:0] exp_idx;
    int         exp_issues;
    bit         poke_start;
    bit         poke_gap;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[4];
  logic [7:0] ref_b0[3];
  logic [7:0] ref_b1[3];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input int n0, input int n1, input int n2);
    int   nk[3];
    exp_t e;
    nk = '{n0, n1, n2};
    for (int i = 0; i < 3; i++) begin
      int attempts;
      attempts = (nk[i] > 3) ? 4 : nk[i] + 1;
      for (int a = 0; a < attempts; a++) begin
        e.idx = i;
        e.b0  = ref_b0[i];
        e.b1  = ref_b1[i];
        sb.push_back(e);
      end
      if (nk[i] > 3) break;
    end
  endtask

  // Acts as the I2C master: always ready, responds 4 cycles after acceptance.
  task automatic run_seq(input int n0, input int n1, input int n2, input int hold_at,
                         input bit poke_start, input bit poke_gap, output int issues);
    int   nk[3];
    int   served[3];
    int   resp_cnt;
    bit   nack_pend;
    bit   poked_s, poked_g, chk_s, chk_g, finished;
    int   gap_exp_idx;
    exp_t e;
    nk = '{n0, n1, n2};
    served = '{0, 0, 0};
    resp_cnt = 0; nack_pend = 0; issues = 0;
    poked_s = 0; poked_g = 0; chk_s = 0; chk_g = 0; finished = 0;
    gap_exp_idx = 0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      resp_valid = 1'b0; resp_ack_err = 1'b0; start = 1'b0; cmd_ready = 1'b0;
      if (chk_s) begin
        check("start_ignored_in_wait_resp", state_info, 4'd3);
        chk_s = 0;
      end
      if (chk_g) begin
        check("spurious_resp_gap_state", state_info, 4'd4);
        check("spurious_resp_gap_index", cur_index, 4'(gap_exp_idx));
        chk_g = 0;
      end
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          resp_valid = 1'b1;
          resp_ack_err = nack_pend;
        end
      end
      if ((init_done || init_error) && resp_cnt == 0 && !resp_valid) begin
        finished = 1;
      end else if (poke_start && !poked_s && state_info == 4'd3 && resp_cnt > 1) begin
        start = 1'b1; poked_s = 1; chk_s = 1;
      end else if (poke_gap && !poked_g && state_info == 4'd4 && resp_cnt == 0 && !resp_valid
                   && sb.size() > 0) begin
        resp_valid = 1'b1; resp_ack_err = 1'b1; poked_g = 1; chk_g = 1;
        gap_exp_idx = sb[0].idx;
      end else if (cmd_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_extra_command", 32'd1, 32'd0);
          finished = 1;
        end else if (sb[0].idx == hold_at) begin
          return;
        end else begin
          cmd_ready = 1'b1;
          e = sb.pop_front();
          check("cmd_dev_addr", cmd_dev_addr, 7'h1A);
          check($sformatf("cmd_byte0_entry%0d", e.idx), cmd_byte0, e.b0);
          check($sformatf("cmd_byte1_entry%0d", e.idx), cmd_byte1, e.b1);
          nack_pend = (served[e.idx] < nk[e.idx]);
          served[e.idx]++;
          issues++;
          resp_cnt = 4;
          $display("accept entry %0d bytes %02h %02h nack=%0d", e.idx, cmd_byte0, cmd_byte1, nack_pend);
        end
      end
    end
    if (!finished) check("sequence_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_start_and_check();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_state_info", state_info, 4'd1);
    check("restart_cur_index", cur_index, 4'd0);
    check("restart_init_done", init_done, 1'b0);
    check("restart_init_error", init_error, 1'b0);
  endtask

  initial begin
    int first_k;
    int bad;
    int issues;
    ref_b0 = '{8'h1E, 8'h0C, 8'h00};
    ref_b1 = '{8'h00, 8'h10, 8'h17};
    //         n0 n1 n2 done  err   state idx  iss poke_s poke_g
    vecs[0] = '{0, 0, 0, 1'b1, 1'b0, 4'd5, 4'd2, 3, 1'b0, 1'b0};
    vecs[1] = '{0, 2, 0, 1'b1, 1'b0, 4'd5, 4'd2, 5, 1'b1, 1'b0};
    vecs[2] = '{0, 0, 9, 1'b0, 1'b1, 4'd6, 4'd2, 6, 1'b0, 1'b0};
    vecs[3] = '{1, 0, 0, 1'b1, 1'b0, 4'd5, 4'd2, 4, 1'b0, 1'b1};

    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state_info", state_info, 4'd1);
    check("reset_cmd_valid", cmd_valid, 1'b0);
    check("reset_init_done", init_done, 1'b0);
    check("reset_init_error", init_error, 1'b0);
    check("reset_cur_index", cur_index, 4'd0);
    check("reset_byte0", cmd_byte0, 8'h1E);
    check("reset_byte1", cmd_byte1, 8'h00);
    reset = 1'b0;

    // First command latency
    first_k = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (cmd_valid) begin
        first_k = k;
        break;
      end
    end
    check("first_cmd_valid_cycle", first_k, 6);

    // Back-pressure: command must stay frozen while not accepted
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_byte0 !== 8'h1E || cmd_byte1 !== 8'h00) bad++;
    end
    check("cmd_held_under_backpressure", bad, 0);

    for (int i = 0; i < 4; i++) begin
      if (i > 0) pulse_start_and_check();
      push_expected(vecs[i].n0, vecs[i].n1, vecs[i].n2);
      run_seq(vecs[i].n0, vecs[i].n1, vecs[i].n2, -1, vecs[i].poke_start, vecs[i].poke_gap, issues);
      check($sformatf("v%0d_queue_drained", i), sb.size(), 0);
      check($sformatf("v%0d_issue_count", i), issues, vecs[i].exp_issues);
      check($sformatf("v%0d_init_done", i), init_done, vecs[i].exp_done);
      check($sformatf("v%0d_init_error", i), init_error, vecs[i].exp_error);
      check($sformatf("v%0d_state_info", i), state_info, vecs[i].exp_state);
      check($sformatf("v%0d_cur_index", i), cur_index, vecs[i].exp_idx);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (cmd_valid !== 1'b0) bad++;
      end
      check($sformatf("v%0d_idle_after_end", i), bad, 0);
      sb.delete();
      $display("vector %0d: issues=%0d done=%0b error=%0b state=%0d idx=%0d",
               i, issues, init_done, init_error, state_info, cur_index);
    end

    // Reset while a command is pending in ISSUE
    pulse_start_and_check();
    push_expected(0, 0, 0);
    run_seq(0, 0, 0, 1, 1'b0, 1'b0, issues);
    check("held_before_reset_valid", cmd_valid, 1'b1);
    sb.delete();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("midreset_cmd_valid", cmd_valid, 1'b0);
    check("midreset_state_info", state_info, 4'd1);
    check("midreset_cur_index", cur_index, 4'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_beats_start", state_info, 4'd1);
    $display("mid-transaction reset: valid=%0b state=%0d idx=%0d", cmd_valid, state_info, cur_index);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
